// File: rtl/chunked_add_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chunked_add_sequencer_if                                             |
// | Request/result handshake bundle for the chunked add/sub sequencer.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface chunked_add_sequencer_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             op_sub;
   logic             is_signed;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   sum;
   logic             ovf;
   logic             busy;

   modport master (
      output in_valid, a, b, op_sub, is_signed, out_ready,
      input  in_ready, out_valid, sum, ovf, busy
   );

   modport slave (
      input  in_valid, a, b, op_sub, is_signed, out_ready,
      output in_ready, out_valid, sum, ovf, busy
   );
endinterface
`default_nettype wire

// File: rtl/chunked_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | chunked_add_sequencer                                                |
// | WIDTH-bit add/sub built from one CHUNK-bit slice over N cycles.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module chunked_add_sequencer #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  wire                     clk,
   input  wire                     rst_n,
   chunked_add_sequencer_if.slave  bus
);
   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_sub;
   logic               r_signed;
   logic               r_carry;
   logic [IDX_W-1:0]   r_idx;
   logic [WIDTH:0]     r_sum;
   logic               r_ovf;

   logic               w_accept;
   logic               w_last;
   logic [CHUNK-1:0]   w_a_k;
   logic [CHUNK-1:0]   w_b_k;
   logic [CHUNK:0]     w_add;
   logic [CHUNK-1:0]   w_s;
   logic               w_c;
   logic               w_ea;
   logic               w_eb;
   logic               w_msb;
   logic               w_ovf;

   assign w_accept = (r_state == S_IDLE) && bus.in_valid;
   assign w_last   = (r_idx == IDX_W'(N - 1));

   // Select the operand slice addressed by the chunk index.
   always_comb begin
      w_a_k = '0;
      w_b_k = '0;
      for (int k = 0; k < N; k++) begin
         if (r_idx == IDX_W'(k)) begin
            w_a_k = r_a[k*CHUNK +: CHUNK];
            w_b_k = r_b[k*CHUNK +: CHUNK];
         end
      end
   end

   assign w_add = {1'b0, w_a_k}
                + {1'b0, w_b_k ^ {CHUNK{r_sub}}}
                + {{CHUNK{1'b0}}, r_carry};
   assign w_s   = w_add[CHUNK-1:0];
   assign w_c   = w_add[CHUNK];

   // Extension bit: sign/zero extend both operands by one bit and finish the add.
   assign w_ea  = r_signed & r_a[WIDTH-1];
   assign w_eb  = (r_signed & r_b[WIDTH-1]) ^ r_sub;
   assign w_msb = w_ea ^ w_eb ^ w_c;
   assign w_ovf = r_signed ? (w_msb ^ w_s[CHUNK-1]) : w_msb;

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: if (bus.in_valid)  w_next_state = S_RUN;
         S_RUN:  if (w_last)        w_next_state = S_DONE;
         S_DONE: if (bus.out_ready) w_next_state = S_IDLE;
         default:                   w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_signed <= 1'b0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_sum    <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_sub    <= bus.op_sub;
            r_signed <= bus.is_signed;
            r_carry  <= bus.op_sub;
            r_idx    <= '0;
         end else if (r_state == S_RUN) begin
            for (int k = 0; k < N; k++) begin
               if (r_idx == IDX_W'(k)) begin
                  r_sum[k*CHUNK +: CHUNK] <= w_s;
               end
            end
            r_carry <= w_c;
            r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
            if (w_last) begin
               r_sum[WIDTH] <= w_msb;
               r_ovf        <= w_ovf;
            end
         end
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.busy      = (r_state != S_IDLE);
   assign bus.sum       = r_sum;
   assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_chunked_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_chunked_add_sequencer                                             |
// | Directed bench for the 64/16 sequencer plus a 16/16 degenerate copy. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_chunked_add_sequencer;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   lat;

   chunked_add_sequencer_if #(.WIDTH(64)) bus ();
   chunked_add_sequencer_if #(.WIDTH(16)) bus1 ();

   chunked_add_sequencer #(.WIDTH(64), .CHUNK(16)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   chunked_add_sequencer #(.WIDTH(16), .CHUNK(16)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Accept one operation, scramble inputs afterwards, count edges to out_valid.
   task automatic run_op(input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic ts, input logic tsg, output int tlat);
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a         = ta;
      bus.b         = tb_v;
      bus.op_sub    = ts;
      bus.is_signed = tsg;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.a         = ~ta;
      bus.b         = ~tb_v;
      bus.op_sub    = ~ts;
      bus.is_signed = ~tsg;
      tlat = 0;
      while (!bus.out_valid && tlat < 20) begin
         @(posedge clk);
         tlat++;
         @(negedge clk);
      end
   endtask

   task automatic finish_op(input string tag);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_in_ready_after"},  {64'd0, bus.in_ready},  65'd1);
      check({tag, "_out_valid_after"}, {64'd0, bus.out_valid}, 65'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;  bus.a = '0;  bus.b = '0;
      bus.op_sub = 1'b0;    bus.is_signed = 1'b0;  bus.out_ready = 1'b1;
      bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0;
      bus1.op_sub = 1'b0;   bus1.is_signed = 1'b0; bus1.out_ready = 1'b1;

      #12;
      check("rst_in_ready",  {64'd0, bus.in_ready},  65'd1);
      check("rst_out_valid", {64'd0, bus.out_valid}, 65'd0);
      check("rst_busy",      {64'd0, bus.busy},      65'd0);
      check("rst_sum",       bus.sum,                65'd0);
      check("rst_ovf",       {64'd0, bus.ovf},       65'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Unsigned add with full carry ripple.
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, lat);
      check("uadd_latency", 65'(lat), 65'd4);
      check("uadd_sum", bus.sum, 65'h1_0000_0000_0000_0000);
      check("uadd_ovf", {64'd0, bus.ovf}, 65'd1);
      finish_op("uadd");

      // 0 - 1 signed, then unsigned.
      run_op(64'd0, 64'd1, 1'b1, 1'b1, lat);
      check("ssub_latency", 65'(lat), 65'd4);
      check("ssub_sum", bus.sum, 65'h1_FFFF_FFFF_FFFF_FFFF);
      check("ssub_ovf", {64'd0, bus.ovf}, 65'd0);
      finish_op("ssub");

      run_op(64'd0, 64'd1, 1'b1, 1'b0, lat);
      check("usub_sum", bus.sum, 65'h1_FFFF_FFFF_FFFF_FFFF);
      check("usub_ovf", {64'd0, bus.ovf}, 65'd1);
      finish_op("usub");

      // Signed positive overflow.
      run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, lat);
      check("sadd_sum", bus.sum, 65'h0_8000_0000_0000_0000);
      check("sadd_ovf", {64'd0, bus.ovf}, 65'd1);
      finish_op("sadd");

      // Backpressure: result held while new request is offered.
      bus.out_ready = 1'b0;
      run_op(64'd5, 64'd6, 1'b0, 1'b0, lat);
      check("bp_latency", 65'(lat), 65'd4);
      bus.in_valid  = 1'b1;
      bus.a         = 64'd100;
      bus.b         = 64'd200;
      bus.op_sub    = 1'b0;
      bus.is_signed = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_out_valid", {64'd0, bus.out_valid}, 65'd1);
         check("bp_in_ready",  {64'd0, bus.in_ready},  65'd0);
         check("bp_sum",       bus.sum,                65'd11);
         check("bp_ovf",       {64'd0, bus.ovf},       65'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_in_ready",  {64'd0, bus.in_ready},  65'd1);
      check("bp_release_out_valid", {64'd0, bus.out_valid}, 65'd0);
      check("bp_release_sum",       bus.sum,                65'd11);

      // Reset while chunk 2 is the next slice to be computed.
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.a         = 64'h1111_2222_3333_4444;
      bus.b         = 64'd1;
      bus.op_sub    = 1'b0;
      bus.is_signed = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("mid_partial_sum", bus.sum, 65'h0_0000_0000_3333_4445);
      check("mid_busy",        {64'd0, bus.busy}, 65'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", {64'd0, bus.out_valid}, 65'd0);
      check("mid_rst_busy",      {64'd0, bus.busy},      65'd0);
      check("mid_rst_sum",       bus.sum,                65'd0);
      check("mid_rst_in_ready",  {64'd0, bus.in_ready},  65'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_out_valid", {64'd0, bus.out_valid}, 65'd0);

      run_op(64'd3, 64'd4, 1'b0, 1'b0, lat);
      check("after_rst_latency", 65'(lat), 65'd4);
      check("after_rst_sum", bus.sum, 65'd7);
      check("after_rst_ovf", {64'd0, bus.ovf}, 65'd0);
      finish_op("after_rst");

      // Degenerate single-slice instance.
      @(negedge clk);
      bus1.in_valid  = 1'b1;
      bus1.a         = 16'h8000;
      bus1.b         = 16'h8000;
      bus1.op_sub    = 1'b0;
      bus1.is_signed = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus1.in_valid = 1'b0;
      check("n1_busy_after_accept", {64'd0, bus1.busy}, 65'd1);
      @(posedge clk);
      @(negedge clk);
      check("n1_out_valid", {64'd0, bus1.out_valid}, 65'd1);
      check("n1_sum",       {48'd0, bus1.sum},       65'h1_0000);
      check("n1_ovf",       {64'd0, bus1.ovf},       65'd1);
      @(posedge clk);
      @(negedge clk);
      check("n1_in_ready_after", {64'd0, bus1.in_ready}, 65'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
